bus_arbiter: RTL and testbench
==============================

# bus_arbiter

Two-master arbiter placed in front of the system `bus` address decoder. It lets the CPU core (master 0) and a second master (master 1, e.g. DMA or debug loader) share the single master port of the interconnect. Bus ownership is granted per transaction and is held until every burst beat has completed, so read data is never returned to the wrong master. Selection between two pending masters is either round-robin or fixed priority.

## Interface
Parameters
- `RR`, 1: 1 = round-robin between pending masters; 0 = fixed priority, master 0 wins.
- `BURST_W`, 4: width of `burstcount`.

Ports (x = 0, 1)
- `clk`  in  1  single system clock; all logic on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `mx_addr`  in  32  master x byte address.
- `mx_wdata`  in  32  master x write data.
- `mx_read`, `mx_write`  in  1  master x command strobes; never both high.
- `mx_dataena`  in  4  master x byte enables.
- `mx_burstcount`  in  BURST_W  master x beats per transaction; 0 is treated as 1.
- `mx_rdata`  out  32  read data to master x.
- `mx_valid`  out  1  read-beat strobe to master x.
- `mx_waitrequest`  out  1  stall to master x.
- `s_addr`, `s_wdata`  out  32  command to the bus.
- `s_read`, `s_write`  out  1  strobes to the bus.
- `s_dataena`  out  4; `s_burstcount`  out  BURST_W.
- `s_rdata`  in  32; `s_valid`, `s_waitrequest`  in  1  response from the bus.
- `grant`  out  2  one-hot current owner, 00 when idle (debug).

## Operation
- The FSM has three states: IDLE, CMD, RBURST. The state, the `grant` register, the `last` pointer (last master served) and the 4-bit `beats` counter are registered. Everything else is combinational from these registers.
- A request from master x is `mx_read | mx_write`.
- IDLE:
  - If there is no request, stay in IDLE.
  - If exactly one master requests, grant it.
  - If both request and RR=1, grant the master that is not `last`. If both request and RR=0, grant master 0.
  - On a grant: load `beats` with the effective burstcount, set `last`, go to CMD.
- CMD:
  - The granted master's addr, wdata, read, write, dataena and burstcount are forwarded combinationally to `s_*`.
  - `s_waitrequest` is forwarded to that master's `mx_waitrequest`.
  - Read accepted (`s_read & !s_waitrequest`): go to RBURST. `s_read` deasserts from the next cycle.
  - Write beat accepted (`s_write & !s_waitrequest`): decrement `beats`. When the beat accepted with `beats` = 1 completes, go to IDLE.
  - If the granted master drops its request before acceptance (a protocol violation), return to IDLE without counting.
- RBURST:
  - `s_read` and `s_write` are 0.
  - Each `s_valid` pulse is forwarded to the granted master with `s_rdata` and decrements `beats`. The pulse with `beats` = 1 returns the FSM to IDLE.
  - New commands from either master are stalled.
- Ungranted master, in every state: `mx_waitrequest` = 1, `mx_valid` = 0, `mx_rdata` = 0.
- In IDLE both `mx_waitrequest` = 1 and all `s_*` outputs are 0.
- `s_valid` received in IDLE or CMD is dropped and not forwarded.

## Timing
- Reset (`rst_n` low, asynchronous):
  - state = IDLE, `grant` = 00, `last` = 1 (so master 0 wins the first RR tie), `beats` = 0.
  - `s_read` = `s_write` = 0, `s_addr` = `s_wdata` = 0, `s_dataena` = 0, `s_burstcount` = 0.
  - `m0_waitrequest` = `m1_waitrequest` = 1, valids = 0, rdata = 0.
- Reset asserted mid-burst aborts the transaction immediately. The bus must be reset at the same time.
- Arbitration latency is 1 cycle. A request first seen at edge N gives a grant at N, and the command appears on `s_*` during cycle N+1.
- Single-beat command with `s_waitrequest` = 0: accepted in cycle N+1, master waitrequest low in N+1.
- Single-beat write: FSM back in IDLE after edge N+1. The next grant is decided at edge N+2, and its command appears on `s_*` in cycle N+3.
- Read: rdata/valid pass through with zero added latency. Grant is released at the edge that samples the last `s_valid`.
- Masters must hold their command stable while `mx_waitrequest` = 1.

## Test plan
- Single write:
  - Stimulus: m0 writes addr 0x2000_0004, wdata 0xDEADBEEF, dataena 0xF, burstcount 1; bus waitrequest 0.
  - Required: `s_write` high exactly 1 cycle with the same fields, `grant` = 01, then IDLE.
- Simultaneous requests, RR=1, after reset:
  - Stimulus: m0 and m1 read together.
  - Required: m0 is served first, m1 is served second, and m1 is stalled (waitrequest 1) throughout m0's transaction.
- Read burst:
  - Stimulus: m1 reads with burstcount 4; bus returns valid on 4 non-contiguous cycles.
  - Required: all 4 beats reach `m1_rdata`/`m1_valid`; m0 sees no valid; a pending m0 request is granted only after the 4th beat.
- Wait states:
  - Stimulus: bus holds `s_waitrequest` = 1 for 3 cycles on an m0 write burst of 2.
  - Required: `m0_waitrequest` mirrors it; exactly 2 beats are counted.
- Fixed priority, RR=0:
  - Stimulus: both masters request continuously.
  - Required: m0 is granted every transaction and m1 is never granted.
- Reset mid-burst:
  - Stimulus: assert `rst_n` = 0 after 2 of 4 read beats.
  - Required: outputs take their reset values asynchronously, and `grant` = 00.

Source files
------------

// File: rtl/bus_arbiter.sv
// Two-master arbiter in front of the bus decoder. Ownership is granted per transaction and held
// until every burst beat completes; ties resolve round-robin (RR=1) or to master 0 (RR=0).
module bus_arbiter #(
   parameter bit          RR      = 1'b1,
   parameter int unsigned BURST_W = 4
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [31:0]        m0_addr,
   input  logic [31:0]        m0_wdata,
   input  logic               m0_read,
   input  logic               m0_write,
   input  logic [3:0]         m0_dataena,
   input  logic [BURST_W-1:0] m0_burstcount,
   output logic [31:0]        m0_rdata,
   output logic               m0_valid,
   output logic               m0_waitrequest,
   input  logic [31:0]        m1_addr,
   input  logic [31:0]        m1_wdata,
   input  logic               m1_read,
   input  logic               m1_write,
   input  logic [3:0]         m1_dataena,
   input  logic [BURST_W-1:0] m1_burstcount,
   output logic [31:0]        m1_rdata,
   output logic               m1_valid,
   output logic               m1_waitrequest,
   output logic [31:0]        s_addr,
   output logic [31:0]        s_wdata,
   output logic               s_read,
   output logic               s_write,
   output logic [3:0]         s_dataena,
   output logic [BURST_W-1:0] s_burstcount,
   input  logic [31:0]        s_rdata,
   input  logic               s_valid,
   input  logic               s_waitrequest,
   output logic [1:0]         grant
);

   typedef enum logic [1:0] {StIdle, StCmd, StRburst} state_e;

   localparam logic [BURST_W-1:0] OneBeat = {{(BURST_W-1){1'b0}}, 1'b1};

   state_e             state_q, state_d;
   logic [1:0]         grant_q, grant_d;
   logic               last_q, last_d;
   logic [BURST_W-1:0] beats_q, beats_d;

   logic               req0, req1, sel, own;
   logic               own_req, own_read, own_write;
   logic [BURST_W-1:0] bc0_eff, bc1_eff;

   assign req0 = m0_read | m0_write;
   assign req1 = m1_read | m1_write;

   // Burstcount 0 is a single beat.
   assign bc0_eff = (m0_burstcount == '0) ? OneBeat : m0_burstcount;
   assign bc1_eff = (m1_burstcount == '0) ? OneBeat : m1_burstcount;

   // Winner among pending masters; only meaningful when at least one requests.
   assign sel = (req0 & req1) ? (RR ? ~last_q : 1'b0) : req1;

   assign own       = grant_q[1];
   assign own_read  = own ? m1_read  : m0_read;
   assign own_write = own ? m1_write : m0_write;
   assign own_req   = own_read | own_write;
   assign grant     = grant_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= StIdle;
         grant_q <= 2'b00;
         last_q  <= 1'b1;
         beats_q <= '0;
      end else begin
         state_q <= state_d;
         grant_q <= grant_d;
         last_q  <= last_d;
         beats_q <= beats_d;
      end
   end

   always_comb begin
      state_d = state_q;
      grant_d = grant_q;
      last_d  = last_q;
      beats_d = beats_q;
      case (state_q)
         StIdle: begin
            if (req0 | req1) begin
               grant_d = sel ? 2'b10 : 2'b01;
               last_d  = sel;
               beats_d = sel ? bc1_eff : bc0_eff;
               state_d = StCmd;
            end
         end
         StCmd: begin
            if (!own_req) begin
               // Master withdrew before acceptance: release without counting.
               state_d = StIdle;
               grant_d = 2'b00;
            end else if (own_read && !s_waitrequest) begin
               state_d = StRburst;
            end else if (own_write && !s_waitrequest) begin
               beats_d = beats_q - OneBeat;
               if (beats_q == OneBeat) begin
                  state_d = StIdle;
                  grant_d = 2'b00;
               end
            end
         end
         StRburst: begin
            if (s_valid) begin
               beats_d = beats_q - OneBeat;
               if (beats_q == OneBeat) begin
                  state_d = StIdle;
                  grant_d = 2'b00;
               end
            end
         end
         default: begin
            state_d = StIdle;
            grant_d = 2'b00;
         end
      endcase
   end

   always_comb begin
      s_addr         = '0;
      s_wdata        = '0;
      s_read         = 1'b0;
      s_write        = 1'b0;
      s_dataena      = '0;
      s_burstcount   = '0;
      m0_waitrequest = 1'b1;
      m1_waitrequest = 1'b1;
      m0_valid       = 1'b0;
      m1_valid       = 1'b0;
      m0_rdata       = '0;
      m1_rdata       = '0;
      if (state_q == StCmd) begin
         s_addr       = own ? m1_addr       : m0_addr;
         s_wdata      = own ? m1_wdata      : m0_wdata;
         s_dataena    = own ? m1_dataena    : m0_dataena;
         s_burstcount = own ? m1_burstcount : m0_burstcount;
         s_read       = own_read;
         s_write      = own_write;
         if (own) m1_waitrequest = s_waitrequest;
         else     m0_waitrequest = s_waitrequest;
      end
      // Read beats pass through with no added latency; valids outside a burst are dropped.
      if (state_q == StRburst) begin
         if (own) begin
            m1_valid = s_valid;
            m1_rdata = s_rdata;
         end else begin
            m0_valid = s_valid;
            m0_rdata = s_rdata;
         end
      end
   end

endmodule

// File: tb/tb_bus_arbiter.sv
// Randomized scoreboard bench for bus_arbiter: masters and bus are behavioural models, and an
// owner/beats reference tracks who may talk to the bus each cycle.
`timescale 1ns/1ps
module tb_bus_arbiter;

   localparam int unsigned BW  = 4;
   localparam int          NTX = 40;

   typedef struct packed {
      logic          wr;
      logic [31:0]   addr;
      logic [31:0]   wdata;
      logic [3:0]    be;
      logic [BW-1:0] bc;
   } cmd_t;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   logic [31:0]   m_addr    [2];
   logic [31:0]   m_wdata   [2];
   logic          m_read    [2];
   logic          m_write   [2];
   logic [3:0]    m_dataena [2];
   logic [BW-1:0] m_bc      [2];
   logic [31:0]   o_rdata   [2];
   logic          o_valid   [2];
   logic          o_wait    [2];
   logic [31:0]   s_addr, s_wdata, s_rdata;
   logic          s_read, s_write, s_valid, s_waitrequest;
   logic [3:0]    s_dataena;
   logic [BW-1:0] s_burstcount;
   logic [1:0]    grant;

   // Second instance in fixed-priority mode, exercised on its own.
   logic          p_m0_write, p_m1_write, p_m0_valid, p_m1_valid, p_m0_wait, p_m1_wait;
   logic [31:0]   p_m0_rdata, p_m1_rdata, p_s_addr, p_s_wdata;
   logic          p_s_read, p_s_write;
   logic [3:0]    p_s_dataena;
   logic [BW-1:0] p_s_burstcount;
   logic [1:0]    p_grant;

   bus_arbiter #(.RR(1'b1), .BURST_W(BW)) dut (
      .clk(clk), .rst_n(rst_n),
      .m0_addr(m_addr[0]), .m0_wdata(m_wdata[0]), .m0_read(m_read[0]), .m0_write(m_write[0]),
      .m0_dataena(m_dataena[0]), .m0_burstcount(m_bc[0]), .m0_rdata(o_rdata[0]),
      .m0_valid(o_valid[0]), .m0_waitrequest(o_wait[0]),
      .m1_addr(m_addr[1]), .m1_wdata(m_wdata[1]), .m1_read(m_read[1]), .m1_write(m_write[1]),
      .m1_dataena(m_dataena[1]), .m1_burstcount(m_bc[1]), .m1_rdata(o_rdata[1]),
      .m1_valid(o_valid[1]), .m1_waitrequest(o_wait[1]),
      .s_addr(s_addr), .s_wdata(s_wdata), .s_read(s_read), .s_write(s_write),
      .s_dataena(s_dataena), .s_burstcount(s_burstcount), .s_rdata(s_rdata),
      .s_valid(s_valid), .s_waitrequest(s_waitrequest), .grant(grant)
   );

   bus_arbiter #(.RR(1'b0), .BURST_W(BW)) dut_fp (
      .clk(clk), .rst_n(rst_n),
      .m0_addr(32'h0000_0100), .m0_wdata(32'h1111_1111), .m0_read(1'b0), .m0_write(p_m0_write),
      .m0_dataena(4'hF), .m0_burstcount(4'd1), .m0_rdata(p_m0_rdata),
      .m0_valid(p_m0_valid), .m0_waitrequest(p_m0_wait),
      .m1_addr(32'h8000_0200), .m1_wdata(32'h2222_2222), .m1_read(1'b0), .m1_write(p_m1_write),
      .m1_dataena(4'hF), .m1_burstcount(4'd1), .m1_rdata(p_m1_rdata),
      .m1_valid(p_m1_valid), .m1_waitrequest(p_m1_wait),
      .s_addr(p_s_addr), .s_wdata(p_s_wdata), .s_read(p_s_read), .s_write(p_s_write),
      .s_dataena(p_s_dataena), .s_burstcount(p_s_burstcount), .s_rdata(32'h0),
      .s_valid(1'b0), .s_waitrequest(1'b0), .grant(p_grant)
   );

   int          n_tests = 0;
   int          n_fail  = 0;
   bit          mon_on  = 1'b0;
   bit          bus_stop = 1'b0;
   cmd_t        exp_cmd [2][$];
   logic [31:0] exp_rd  [2][$];

   function automatic void chk(input string name, input logic [127:0] act,
                               input logic [127:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endfunction

   function automatic void timeout(input string name, input int cycles);
      n_tests++;
      n_fail++;
      $display("FAIL %s: no response within %0d cycles", name, cycles);
   endfunction

   function automatic int eff(input logic [BW-1:0] b);
      return (b == '0) ? 1 : int'(b);
   endfunction

   function automatic logic [31:0] bus_data(input logic [31:0] a, input int k);
      return a ^ (32'(k) * 32'h1357_9BDF) ^ 32'hC0DE_0000;
   endfunction

   // Reference: who owns the bus, whether it is collecting read data, and beats still owed.
   int own = -1, left = 0, last_m = 1;
   bit rdph = 1'b0;

   always @(negedge clk) begin : monitor
      int   o;
      bit   r0, r1;
      cmd_t c;
      if (!rst_n) begin
         own = -1; left = 0; last_m = 1; rdph = 1'b0;
      end else if (mon_on) begin
         o = (own < 0) ? 0 : own;
         chk("grant", {126'd0, grant}, (own < 0) ? 0 : (own == 0 ? 1 : 2));
         for (int x = 0; x < 2; x++) begin
            chk($sformatf("m%0d_waitrequest", x), o_wait[x],
                (own == x && !rdph) ? s_waitrequest : 1'b1);
            chk($sformatf("m%0d_valid", x), o_valid[x], (own == x) && rdph && s_valid);
            if (own != x) chk($sformatf("m%0d_rdata_ungranted", x), o_rdata[x], 0);
            if (o_valid[x]) begin
               if (exp_rd[x].size() == 0) chk($sformatf("m%0d_unexpected_beat", x), 1, 0);
               else chk($sformatf("m%0d_rdata", x), o_rdata[x], exp_rd[x].pop_front());
            end
         end
         chk("s_read", s_read, (own >= 0) && !rdph && m_read[o]);
         chk("s_write", s_write, (own >= 0) && !rdph && m_write[o]);
         if (own < 0)
            chk("s_idle_fields", {s_addr, s_wdata, s_dataena, s_burstcount}, 0);
         if ((s_read || s_write) && !s_waitrequest && own >= 0) begin
            if (exp_cmd[own].size() == 0) chk("s_unexpected_cmd", 1, 0);
            else begin
               c = exp_cmd[own].pop_front();
               chk($sformatf("m%0d_cmd_on_bus", own),
                   {s_write, s_addr, s_wdata, s_dataena, s_burstcount}, c);
            end
         end
         // Advance the reference to what the coming edge does.
         r0 = m_read[0] || m_write[0];
         r1 = m_read[1] || m_write[1];
         if (own < 0) begin
            if (r0 || r1) begin
               own    = (r0 && r1) ? 1 - last_m : (r0 ? 0 : 1);
               last_m = own;
               left   = eff(m_bc[own]);
               rdph   = 1'b0;
            end
         end else if (!rdph) begin
            if (!(m_read[own] || m_write[own])) own = -1;
            else if (!s_waitrequest) begin
               if (m_read[own]) rdph = 1'b1;
               else begin
                  left--;
                  if (left == 0) own = -1;
               end
            end
         end else if (s_valid) begin
            left--;
            if (left == 0) begin
               own  = -1;
               rdph = 1'b0;
            end
         end
      end
   end

   task automatic wait_accept(input int x);
      bit acc = 1'b0;
      int n   = 0;
      while (!acc && n < 300) begin
         @(negedge clk);
         acc = !o_wait[x];
         n++;
         @(posedge clk);
         #1;
      end
      if (!acc) timeout($sformatf("m%0d_accept", x), n);
   endtask

   task automatic run_master(input int x, input int ntx);
      for (int t = 0; t < ntx; t++) begin
         logic [BW-1:0] bc;
         logic [31:0]   a;
         cmd_t          c;
         bit            wr;
         int            nb, got, n;
         // First transactions of both masters start together to exercise the tie after reset.
         if (t != 0) repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
         wr = 1'($urandom_range(0, 1));
         bc = BW'($urandom_range(0, 4));
         nb = eff(bc);
         a  = $urandom;
         a[31] = (x == 1);
         m_addr[x] = a;
         m_bc[x]   = bc;
         if (!wr) for (int k = 0; k < nb; k++) exp_rd[x].push_back(bus_data(a, k));
         for (int k = 0; k < (wr ? nb : 1); k++) begin
            c.wr = wr; c.addr = a; c.wdata = $urandom; c.be = 4'($urandom); c.bc = bc;
            m_wdata[x]   = c.wdata;
            m_dataena[x] = c.be;
            m_write[x]   = wr;
            m_read[x]    = !wr;
            exp_cmd[x].push_back(c);
            wait_accept(x);
         end
         m_write[x] = 1'b0;
         m_read[x]  = 1'b0;
         if (!wr) begin
            got = 0;
            n   = 0;
            while (got < nb && n < 400) begin
               @(negedge clk);
               if (o_valid[x]) got++;
               n++;
               @(posedge clk);
               #1;
            end
            if (got < nb) timeout($sformatf("m%0d_read_beats", x), n);
         end
      end
   endtask

   task automatic run_bus();
      int          pend = 0, k = 0;
      logic [31:0] ra   = '0;
      while (!bus_stop) begin
         @(negedge clk);
         if (s_read && !s_waitrequest) begin
            pend = eff(s_burstcount);
            ra   = s_addr;
            k    = 0;
         end else if (s_valid && pend > 0) begin
            pend--;
            k++;
         end
         @(posedge clk);
         #1;
         s_waitrequest = ($urandom_range(0, 9) < 4);
         if (pend > 0) begin
            s_valid = 1'($urandom_range(0, 1));
            s_rdata = s_valid ? bus_data(ra, k) : $urandom;
         end else begin
            s_valid = ($urandom_range(0, 9) == 0);   // stray pulse, must be dropped
            s_rdata = $urandom;
         end
      end
      s_valid       = 1'b0;
      s_waitrequest = 1'b0;
   endtask

   initial begin
      for (int x = 0; x < 2; x++) begin
         m_addr[x] = '0; m_wdata[x] = '0; m_read[x] = 1'b0; m_write[x] = 1'b0;
         m_dataena[x] = '0; m_bc[x] = '0;
      end
      s_rdata = '0; s_valid = 1'b0; s_waitrequest = 1'b0;
      p_m0_write = 1'b0; p_m1_write = 1'b0;
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("reset_grant", grant, 0);
      chk("reset_waitrequest", {o_wait[0], o_wait[1]}, 2'b11);
      chk("reset_bus_outputs", {s_read, s_write, s_addr, s_wdata, s_dataena, s_burstcount}, 0);
      chk("reset_fp_grant", p_grant, 0);
      rst_n  = 1'b1;
      mon_on = 1'b1;
      fork
         begin
            fork
               run_master(0, NTX);
               run_master(1, NTX);
            join
            bus_stop = 1'b1;
         end
         run_bus();
      join
      mon_on = 1'b0;
      for (int x = 0; x < 2; x++) begin
         chk($sformatf("m%0d_cmds_outstanding", x), exp_cmd[x].size(), 0);
         chk($sformatf("m%0d_beats_outstanding", x), exp_rd[x].size(), 0);
      end

      // Read burst of 4 from m1, m0 pending; reset lands after two beats.
      @(posedge clk);
      #1;
      m_read[1] = 1'b1; m_addr[1] = 32'h8000_0100; m_bc[1] = 4'd4;
      @(posedge clk);
      #1;
      chk("burst_grant", grant, 2'b10);
      chk("burst_s_read", s_read, 1);
      @(posedge clk);
      #1;
      m_read[1] = 1'b0;
      m_read[0] = 1'b1; m_addr[0] = 32'h0000_0040; m_bc[0] = 4'd1;
      for (int k = 0; k < 2; k++) begin
         s_valid = 1'b1;
         s_rdata = 32'hB000_0000 + 32'(k);
         #1;
         chk("burst_m1_valid", o_valid[1], 1);
         chk("burst_m0_stalled", {o_wait[0], o_valid[0]}, 2'b10);
         @(posedge clk);
         #1;
         s_valid = 1'b0;
         @(posedge clk);
         #1;
      end
      s_valid = 1'b1;
      s_rdata = 32'hB000_0002;
      #1;
      chk("burst_third_beat", {grant, o_valid[1], o_rdata[1]}, {2'b10, 1'b1, 32'hB000_0002});
      #2;
      rst_n = 1'b0;
      #1;
      chk("midreset_grant", grant, 0);
      chk("midreset_master_side",
          {o_wait[0], o_wait[1], o_valid[0], o_valid[1], o_rdata[0], o_rdata[1]}, {2'b11, 66'd0});
      chk("midreset_bus_side", {s_read, s_write, s_addr, s_wdata, s_dataena, s_burstcount}, 0);
      @(posedge clk);
      #1;
      chk("midreset_held", grant, 0);
      s_valid   = 1'b0;
      m_read[0] = 1'b0;
      rst_n     = 1'b1;

      // Fixed priority: both masters write back-to-back, master 0 must win every time.
      @(posedge clk);
      #1;
      p_m0_write = 1'b1;
      p_m1_write = 1'b1;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         chk($sformatf("fp_grant_%0d", i), p_grant, (i % 2 == 1) ? 2'b01 : 2'b00);
         chk($sformatf("fp_m1_stalled_%0d", i), p_m1_wait, 1);
         chk($sformatf("fp_s_write_%0d", i), p_s_write, i % 2 == 1);
      end
      p_m0_write = 1'b0;
      p_m1_write = 1'b0;

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
